parity_frame_checker: RTL and testbench

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

---
 rtl/parity_pkg.sv | 21 ++
 rtl/xorgate.sv | 10 +
 rtl/parity_frame_checker.sv | 123 ++++++++++++
 tb/tb_parity_frame_checker.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared FSM state encoding and parity-mode constants
package parity_pkg;

  // Parity mode selectors for the ODD parameter
  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  // Frame checker FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Bit that is folded into the final parity result for the selected mode
  function automatic logic parity_mode_bit(input int odd);
    return (odd != PAR_EVEN);
  endfunction

endpackage

// File: rtl/xorgate.sv
// rtl/xorgate.sv - two-input xor used for the running parity update
module xorgate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial frame receiver with data word capture and parity check
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ODD       = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               din,
  input  logic                               din_valid,
  output logic                               busy,
  output logic                               done,
  output logic                               parity_err,
  output logic [DATA_BITS-1:0]               data_out,
  output logic [$clog2(DATA_BITS+1)-1:0]     bit_cnt
);

  localparam int            CW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BITS - 1);
  localparam logic          ODD_BIT  = parity_mode_bit(ODD);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   acc_q, acc_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   acc_next;

  // Running parity: accumulator xor the bit currently on din
  xorgate u_acc_xor (
    .a_i (acc_q),
    .b_i (din),
    .y_o (acc_next)
  );

  // Next-state, datapath update and registered-output precompute
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    perr_d  = perr_q;

    case (state_q)
      IDLE: begin
        // din_valid is deliberately ignored here, even alongside start
        if (start) begin
          state_d = DATA;
          cnt_d   = '0;
          acc_d   = 1'b0;
          data_d  = '0;
          perr_d  = 1'b0;
        end
      end

      DATA: begin
        if (din_valid) begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (CW'(i) == cnt_q) begin
              data_d[i] = din;
            end
          end
          acc_d = acc_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = PARITY;
          end
        end
      end

      PARITY: begin
        // bit_cnt already sits at DATA_BITS and is left there
        if (din_valid) begin
          perr_d  = acc_next ^ ODD_BIT;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == DATA) || (state_d == PARITY);
    done_d = (state_d == DONE);
  end

  // State and output registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign parity_err = perr_q;
  assign data_out   = data_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - self-checking bench for parity_frame_checker (even and odd instances)
module tb_parity_frame_checker;

  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic din;
  logic din_valid;

  logic       busy_e, done_e, perr_e;
  logic [7:0] data_e;
  logic [3:0] cnt_e;
  logic       busy_o, done_o, perr_o;
  logic [7:0] data_o;
  logic [3:0] cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  bit       m_busy, m_done, m_perr_e, m_perr_o;
  bit [7:0] m_data;
  int       m_cnt;

  typedef struct {
    logic [7:0] data;
    bit         pbit;
    int         gap;
    bit         start_dv;
    bit         noise;
    bit         exp_e;
    bit         exp_o;
  } vec_t;

  vec_t tbl [6];

  parity_frame_checker #(.DATA_BITS(DB), .ODD(0)) dut_e (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .busy       (busy_e),
    .done       (done_e),
    .parity_err (perr_e),
    .data_out   (data_e),
    .bit_cnt    (cnt_e)
  );

  parity_frame_checker #(.DATA_BITS(DB), .ODD(1)) dut_o (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .busy       (busy_o),
    .done       (done_o),
    .parity_err (perr_o),
    .data_out   (data_o),
    .bit_cnt    (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("busy_even",  busy_e, m_busy);
    check("done_even",  done_e, m_done);
    check("perr_even",  perr_e, m_perr_e);
    check("data_even",  data_e, m_data);
    check("cnt_even",   cnt_e,  m_cnt);
    check("busy_odd",   busy_o, m_busy);
    check("done_odd",   done_o, m_done);
    check("perr_odd",   perr_o, m_perr_o);
    check("data_odd",   data_o, m_data);
    check("cnt_odd",    cnt_o,  m_cnt);
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_perr_e = 0; m_perr_o = 0; m_data = '0; m_cnt = 0;
  endtask

  // Frame-level behaviour: collect DB bits, then judge the parity bit against the word
  task automatic model_step(input bit s, input bit d, input bit v);
    if (m_done) begin
      m_done = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_cnt = 0; m_data = '0; m_perr_e = 0; m_perr_o = 0;
      end
    end else if (v) begin
      if (m_cnt < DB) begin
        m_data[m_cnt] = d;
        m_cnt++;
      end else begin
        m_perr_e = (^m_data) ^ d;
        m_perr_o = ~((^m_data) ^ d);
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic tick(input bit s, input bit d, input bit v);
    start = s; din = d; din_valid = v;
    @(posedge clk);
    model_step(s, d, v);
    #1;
    check_all();
    start = 1'b0; din_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit p, input int gap,
                            input bit start_dv, input bit noise);
    tick(1'b1, ~data[0], start_dv);
    for (int i = 0; i < DB; i++) begin
      repeat (gap) tick(noise, 1'($urandom), 1'b0);
      tick(noise, data[i], 1'b1);
    end
    repeat (gap) tick(noise, 1'($urandom), 1'b0);
    tick(noise, p, 1'b1);
    check("done_after_parity_even", done_e, 1'b1);
    check("done_after_parity_odd",  done_o, 1'b1);
    tick(noise, 1'($urandom), 1'($urandom));
    check("done_one_cycle_even", done_e, 1'b0);
    check("idle_after_done_even", busy_e, 1'b0);
  endtask

  task automatic reset_mid_frame();
    tick(1'b1, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_busy_even", busy_e, 1'b0);
    check("rst_cnt_even",  cnt_e,  4'd0);
    check("rst_data_odd",  data_o, 8'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'hA5, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h01, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h01, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h3C, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'hFF, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      if (i == 5) reset_mid_frame();
      send_frame(tbl[i].data, tbl[i].pbit, tbl[i].gap, tbl[i].start_dv, tbl[i].noise);
      repeat (3) tick(1'b0, 1'($urandom), 1'($urandom));
      check("tbl_data_even", data_e, tbl[i].data);
      check("tbl_data_odd",  data_o, tbl[i].data);
      check("tbl_perr_even", perr_e, tbl[i].exp_e);
      check("tbl_perr_odd",  perr_o, tbl[i].exp_o);
    end

    for (int f = 0; f < 40; f++) begin
      logic [7:0] rd;
      rd = 8'($urandom);
      tick(1'b1, 1'($urandom), 1'($urandom));
      for (int b = 0; b < DB; b++) begin
        repeat ($urandom_range(0, 2)) tick(1'($urandom), 1'($urandom), 1'b0);
        tick(1'($urandom), rd[b], 1'b1);
      end
      repeat ($urandom_range(0, 2)) tick(1'($urandom), 1'($urandom), 1'b0);
      tick(1'($urandom), 1'($urandom), 1'b1);
      check("rand_data_even", data_e, rd);
      repeat ($urandom_range(1, 4)) tick(1'b0, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
